// File: rtl/gate_ctrl_pkg.sv
// Shared control definitions for the multi-cycle datapath: FSM state
// encoding, opcode constants, opcode class decodes and mux select codes.
package gate_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_BRZ   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hB;
  localparam logic [3:0] OP_LOADI = 4'hF;

  localparam logic [1:0] PCSRC_INC    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_IMM = 2'd2;

  // Immediate-operand class: ALU immediate ops and LOADI (1100-1111).
  function automatic logic isAluImm(input logic [3:0] op);
    return op >= 4'hC;
  endfunction

  // Opcodes that need the MEM state.
  function automatic logic isMem(input logic [3:0] op);
    return (op == OP_STORE) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory handshake watchdog: counts request cycles that go unacknowledged
// and flags expiry on the cycle the count would reach TIMEOUT.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, otherwise step on each unacknowledged request.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !ack_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register; reset arrives through clear_i.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  // An ack in the expiring cycle suppresses expiry.
  assign expired_o = enable_i && !ack_i && (count_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing,
// opcode decode, memory watchdog and retired-instruction counter.
module instr_sequencer
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       Opcode,
  input  logic             zeroFlag,
  input  logic             memAck,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             memRead,
  output logic             memWrite,
  output logic             memAddrSel,
  output logic             regWrite,
  output logic [1:0]       wbSel,
  output logic             aluSrcImm,
  output logic [3:0]       aluOp,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             wd_clear, wd_enable, wd_expired;

  // State and retired-count registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Next-state and retire decision; reset suppresses both.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (run) begin
            if (memAck)          state_d = DECODE;
            else if (wd_expired) state_d = FAULT;
          end
        end
        DECODE: begin
          if (Opcode == OP_NOP) begin
            state_d = FETCH;
            retire  = 1'b1;
          end else if (Opcode == OP_HALT) begin
            state_d = HALT;
          end else begin
            state_d = EXECUTE;
          end
        end
        EXECUTE: begin
          if (Opcode == OP_BRZ || Opcode == OP_JMP) begin
            state_d = FETCH;
            retire  = 1'b1;
          end else if (isMem(Opcode)) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          if (memAck) begin
            if (Opcode == OP_STORE) begin
              state_d = FETCH;
              retire  = 1'b1;
            end else begin
              state_d = WB;
            end
          end else if (wd_expired) begin
            state_d = FAULT;
          end
        end
        WB: begin
          state_d = FETCH;
          retire  = 1'b1;
        end
        HALT:    state_d = HALT;
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  // Moore output decode; irWrite/pcWrite in FETCH are qualified by memAck.
  always_comb begin
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = PCSRC_INC;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memAddrSel = 1'b0;
    regWrite   = 1'b0;
    wbSel      = WBSEL_ALU;
    aluSrcImm  = 1'b0;
    aluOp      = '0;
    halted     = 1'b0;
    fault      = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (run) begin
            memRead = 1'b1;
            if (memAck) begin
              irWrite = 1'b1;
              pcWrite = 1'b1;
              pcSrc   = PCSRC_INC;
            end
          end
        end
        EXECUTE: begin
          aluOp     = Opcode;
          aluSrcImm = isAluImm(Opcode) || isMem(Opcode);
          if (Opcode == OP_BRZ) begin
            pcWrite = zeroFlag;
            pcSrc   = PCSRC_BRANCH;
          end else if (Opcode == OP_JMP) begin
            pcWrite = 1'b1;
            pcSrc   = PCSRC_JUMP;
          end
        end
        MEM: begin
          memAddrSel = 1'b1;
          memRead    = (Opcode == OP_LOAD);
          memWrite   = (Opcode == OP_STORE);
        end
        WB: begin
          regWrite = 1'b1;
          if (Opcode == OP_LOAD)       wbSel = WBSEL_MEM;
          else if (Opcode == OP_LOADI) wbSel = WBSEL_IMM;
          else                         wbSel = WBSEL_ALU;
        end
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: ;
      endcase
    end
  end

  // Watchdog restarts on every state change (entry) and on reset.
  assign wd_clear  = reset || (state_d != state_q);
  assign wd_enable = memRead || memWrite;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (CLK),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .ack_i     (memAck),
    .expired_o (wd_expired)
  );

  assign state   = state_q;
  assign retired = retired_q;

endmodule
